// File: rtl/apb_completer_regbank_pkg.sv
// Shared encodings, default widths and the ID constant for the APB register-bank completer.
package apb_pkg;

    localparam int unsigned ADDR_SIZE_DEF = 32;
    localparam int unsigned DATA_SIZE_DEF = 32;
    localparam int unsigned PROT_SIZE_DEF = 3;
    localparam int unsigned CNT_W         = 4;

    localparam logic [31:0] ID_VALUE_DEF = 32'hA9B0_0001;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] WAIT_ENC  = 2'd1;
    localparam logic [1:0] READY_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        WAIT  = WAIT_ENC,
        READY = READY_ENC
    } apb_state_e;

endpackage

// File: rtl/apb_completer_regbank_if.sv
// APB bus bundle between the bridge (master) and a completer (slave).
interface apb_completer_regbank_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned PROT_SIZE = PROT_SIZE_DEF,
    parameter int unsigned STRB_SIZE = DATA_SIZE / 8
);
    logic                 PSELX;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [ADDR_SIZE-1:0] PADDR;
    logic [DATA_SIZE-1:0] PWDATA;
    logic [PROT_SIZE-1:0] PPROT;
    logic [STRB_SIZE-1:0] PSTRB;
    logic [DATA_SIZE-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PSELX, PENABLE, PWRITE, PADDR, PWDATA, PPROT, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELX, PENABLE, PWRITE, PADDR, PWDATA, PPROT, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_completer_regbank_regbank.sv
// Register array with byte-strobe write port and combinational read port; entry 0 reads as ID.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int unsigned          NUM_REGS  = 16,
    parameter int unsigned          DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned          STRB_SIZE = DATA_SIZE / 8,
    parameter logic [DATA_SIZE-1:0] ID_VALUE  = DATA_SIZE'(ID_VALUE_DEF)
)
(
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] widx,
    input  logic [STRB_SIZE-1:0]        wstrb,
    input  logic [DATA_SIZE-1:0]        wdata,
    input  logic [$clog2(NUM_REGS)-1:0] ridx,
    output logic [DATA_SIZE-1:0]        rdata_c
);
    logic [DATA_SIZE-1:0] regs [NUM_REGS];

    // Strobe-masked write; index 0 is read-only and never written.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && (widx != '0)) begin
            for (int b = 0; b < STRB_SIZE; b++) begin
                if (wstrb[b]) regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read port with the ID constant overlaid on index 0.
    always_comb begin
        rdata_c = regs[ridx];
        if (ridx == '0) rdata_c = ID_VALUE;
    end
endmodule

// File: rtl/apb_completer_regbank.sv
// APB completer: FSM with programmable wait states, decode/error checks and a register bank.
module apb_completer_regbank
    import apb_pkg::*;
#(
    parameter int unsigned          ADDR_SIZE   = ADDR_SIZE_DEF,
    parameter int unsigned          DATA_SIZE   = DATA_SIZE_DEF,
    parameter int unsigned          PROT_SIZE   = PROT_SIZE_DEF,
    parameter int unsigned          STRB_SIZE   = DATA_SIZE / 8,
    parameter int unsigned          NUM_REGS    = 16,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = '0,
    parameter int unsigned          WAIT_CYCLES = 2,
    parameter logic [DATA_SIZE-1:0] ID_VALUE    = DATA_SIZE'(ID_VALUE_DEF)
)
(
    input  logic                    PCLK,
    input  logic                    PRESET,
    apb_completer_regbank_if.slave  bus
);
    localparam int unsigned LANE_BITS = $clog2(STRB_SIZE);
    localparam int unsigned IDX_W     = $clog2(NUM_REGS);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

    apb_state_e           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;

    logic                 write_q, err_q;
    logic [IDX_W-1:0]     idx_q;
    logic [STRB_SIZE-1:0] strb_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic                 pready_q, pslverr_q;
    logic [DATA_SIZE-1:0] prdata_q;

    logic [ADDR_SIZE-1:0] off_c;
    logic                 in_range_c, misalign_c, err_c, setup_c, enter_ready_c;
    logic                 err_sel_c, write_sel_c, commit_c;
    logic [IDX_W-1:0]     idx_c, rd_idx_c;
    logic [DATA_SIZE-1:0] rd_data_c;

    // Address decode and error classification of the live setup phase.
    always_comb begin
        off_c      = bus.PADDR - BASE_ADDR;
        in_range_c = (bus.PADDR >= BASE_ADDR) && (off_c < ADDR_SIZE'(NUM_REGS * STRB_SIZE));
        misalign_c = (bus.PADDR & ADDR_SIZE'(STRB_SIZE - 1)) != '0;
        idx_c      = IDX_W'(off_c >> LANE_BITS);
        err_c      = !in_range_c || misalign_c
                   || (bus.PWRITE && (idx_c == '0))
                   || (!bus.PPROT[0] && (idx_c >= IDX_W'(NUM_REGS / 2)));
    end

    // FSM and wait-counter state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; dropping PSELX mid-access aborts back to IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        setup_c   = 1'b0;
        unique case (state)
            IDLE: begin
                setup_c = bus.PSELX && !bus.PENABLE;
                if (setup_c) begin
                    state_nxt = NO_WAIT ? READY : WAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (!bus.PSELX)       state_nxt = IDLE;
                else if (cnt == '0)   state_nxt = READY;
                else                  cnt_nxt   = cnt - CNT_W'(1);
            end
            READY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-wait transfers enter READY straight from IDLE, so use live decode there.
    always_comb begin
        enter_ready_c = (state_nxt == READY);
        err_sel_c     = (state == IDLE) ? err_c        : err_q;
        write_sel_c   = (state == IDLE) ? bus.PWRITE   : write_q;
        rd_idx_c      = (state == IDLE) ? idx_c        : idx_q;
        commit_c      = (state == READY) && bus.PSELX && write_q && !err_q;
    end

    // Setup-phase capture and registered bus outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            if (setup_c) begin
                write_q <= bus.PWRITE;
                err_q   <= err_c;
                idx_q   <= idx_c;
                strb_q  <= bus.PSTRB;
                wdata_q <= bus.PWDATA;
            end
            pready_q  <= enter_ready_c;
            pslverr_q <= enter_ready_c && err_sel_c;
            if (enter_ready_c) prdata_q <= (err_sel_c || write_sel_c) ? '0 : rd_data_c;
        end
    end

    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PRDATA  = prdata_q;

    apb_regbank #(
        .NUM_REGS  (NUM_REGS),
        .DATA_SIZE (DATA_SIZE),
        .STRB_SIZE (STRB_SIZE),
        .ID_VALUE  (ID_VALUE)
    ) u_regbank (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .we      (commit_c),
        .widx    (idx_q),
        .wstrb   (strb_q),
        .wdata   (wdata_q),
        .ridx    (rd_idx_c),
        .rdata_c (rd_data_c)
    );
endmodule
